// File: rtl/hdmi_packet_pkg.sv
// Shared definitions for the HDMI data-island packet receiver: packet type
// codes, the unpack FSM state type, the audio sample FIFO entry and small
// byte/bit helpers used by the receiver datapath.
package hdmi_packet_pkg;

  // Data-island packet type codes (HB0)
  localparam logic [7:0] NULL         = 8'h00;
  localparam logic [7:0] ACR          = 8'h01;
  localparam logic [7:0] AUDIO_SAMPLE = 8'h02;
  localparam logic [7:0] AVI          = 8'h82;
  localparam logic [7:0] AUDIO_INFO   = 8'h84;

  typedef enum logic {
    IDLE,
    UNPACK
  } unpackState_e;

  // One FIFO entry: full 24-bit IEC 60958 sample fields plus the B flag.
  // Truncation to the configured output width happens at the receiver output.
  typedef struct packed {
    logic [23:0] left;
    logic [23:0] right;
    logic        blockStart;
  } audioSample_t;

  // Byte idx (0 = SB0) of a 56-bit subpacket
  function automatic logic [7:0] subByte(input logic [55:0] sb, input int idx);
    return sb[idx*8 +: 8];
  endfunction

  // Byte idx (0 = HB0) of the 24-bit header
  function automatic logic [7:0] headerByte(input logic [23:0] hb, input int idx);
    return hb[idx*8 +: 8];
  endfunction

  // Lowest set bit of mask at position >= start; returns {found, index}
  function automatic logic [2:0] findSetFrom(input logic [3:0] mask, input logic [2:0] start);
    logic [2:0] result;
    result = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (i >= int'(start))) begin
        result = {1'b1, 2'(i)};
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/hdmi_audio_sample_fifo.sv
// First-word fall-through sample FIFO between the packet unpacker and the
// audio recovery logic. A push into a full FIFO only succeeds when a pop
// frees a slot on the same edge; otherwise the sample is dropped and the
// saturating overflow counter records it.
module hdmi_audio_sample_fifo
  import hdmi_packet_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              push_valid_i,
  input  logic [$bits(audioSample_t)-1:0]   push_data_i,
  input  logic                              pop_ready_i,
  output logic                              pop_valid_o,
  output logic [$bits(audioSample_t)-1:0]   pop_data_o,
  output logic [7:0]                        overflow_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [$bits(audioSample_t)-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W:0]   count_q;
  logic [7:0]       overflow_q;

  logic notEmpty;
  logic full;
  logic popFire;
  logic pushFire;

  assign notEmpty = (count_q != '0);
  assign full     = (count_q == FULL_COUNT);
  assign popFire  = notEmpty && pop_ready_i;
  assign pushFire = push_valid_i && (!full || popFire);

  // Storage, pointers, occupancy and overflow counter; memory is cleared so the
  // output word reads zero straight after reset
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= '0;
    end else begin
      if (pushFire) begin
        mem_q[wrPtr_q] <= push_data_i;
        wrPtr_q        <= wrPtr_q + PTR_W'(1);
      end
      if (popFire) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      case ({pushFire, popFire})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
      if (push_valid_i && !pushFire && (overflow_q != 8'hFF)) begin
        overflow_q <= overflow_q + 8'd1;
      end
    end
  end

  assign pop_valid_o      = notEmpty;
  assign pop_data_o       = mem_q[rdPtr_q];
  assign overflow_count_o = overflow_q;

endmodule

// File: rtl/hdmi_packet_receiver.sv
// Sink-side data-island packet receiver. Captures one BCH-checked packet,
// then on the following edge dispatches it: ACR updates N/CTS, AVI and Audio
// InfoFrames are checksum-checked and latched, audio sample packets are
// unpacked one present subpacket per cycle into the sample FIFO.
module hdmi_packet_receiver
  import hdmi_packet_pkg::*;
#(
  parameter int AUDIO_BIT_WIDTH   = 16,
  parameter int SAMPLE_FIFO_DEPTH = 8
) (
  input  logic                            clk_pixel,
  input  logic                            reset_n,
  input  logic                            packet_valid,
  input  logic                            ecc_error,
  input  logic [23:0]                     header,
  input  logic [3:0][55:0]                sub,
  output logic [1:0][AUDIO_BIT_WIDTH-1:0] audio_sample_word,
  output logic                            audio_block_start,
  output logic                            audio_sample_valid,
  input  logic                            audio_sample_ready,
  output logic [19:0]                     cts,
  output logic [19:0]                     n,
  output logic                            acr_valid,
  output logic [6:0]                      video_id_code,
  output logic [2:0]                      channel_count,
  output logic                            info_frame_checksum_error,
  output logic [7:0]                      sample_overflow_count,
  output logic                            protocol_error
);

  logic             capValid_q;
  logic [23:0]      capHeader_q;
  logic [3:0][55:0] capSub_q;
  unpackState_e     state_q;
  unpackState_e     state_d;
  logic [1:0]       idx_q;
  logic [1:0]       idx_d;
  logic [19:0]      cts_q;
  logic [19:0]      n_q;
  logic             acrValid_q;
  logic [6:0]       vic_q;
  logic [2:0]       channelCount_q;
  logic             checksumError_q;
  logic             protocolError_q;

  logic [7:0]   hb0;
  logic [3:0]   present;
  logic [3:0]   blockFlags;
  logic [2:0]   firstHit;
  logic [2:0]   nextHit;
  logic         pushValid_d;
  logic [1:0]   pushIdx_d;
  audioSample_t pushEntry_d;
  logic [7:0]   checksum_d;
  logic         accept_d;
  logic         busy_d;
  audioSample_t fifoHead;
  logic         unusedHighBits;

  assign hb0        = capHeader_q[7:0];
  assign present    = capHeader_q[11:8];
  assign blockFlags = capHeader_q[23:20];
  assign accept_d   = packet_valid && !ecc_error;
  // The capture register feeds the unpacker, so a new packet cannot be taken
  // while the unpacker is running or about to start
  assign busy_d     = (state_q == UNPACK) || (state_d == UNPACK);

  // Unpack sequencing: the first present subpacket is pushed on the dispatch
  // edge itself, the rest one per cycle in UNPACK
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pushValid_d = 1'b0;
    pushIdx_d   = idx_q;
    firstHit    = '0;
    nextHit     = '0;
    case (state_q)
      IDLE: begin
        firstHit = findSetFrom(present, 3'd0);
        if (capValid_q && (hb0 == AUDIO_SAMPLE) && firstHit[2]) begin
          pushValid_d = 1'b1;
          pushIdx_d   = firstHit[1:0];
          nextHit     = findSetFrom(present, {1'b0, firstHit[1:0]} + 3'd1);
          if (nextHit[2]) begin
            state_d = UNPACK;
            idx_d   = nextHit[1:0];
          end
        end
      end
      UNPACK: begin
        pushValid_d = 1'b1;
        pushIdx_d   = idx_q;
        nextHit     = findSetFrom(present, {1'b0, idx_q} + 3'd1);
        if (nextHit[2]) begin
          idx_d = nextHit[1:0];
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sample entry for the subpacket currently being unpacked
  always_comb begin
    pushEntry_d            = '0;
    pushEntry_d.left       = capSub_q[pushIdx_d][23:0];
    pushEntry_d.right      = capSub_q[pushIdx_d][47:24];
    pushEntry_d.blockStart = blockFlags[pushIdx_d];
  end

  // InfoFrame checksum: mod-256 sum over the header and all 28 subpacket bytes
  always_comb begin
    checksum_d = '0;
    for (int b = 0; b < 3; b++) begin
      checksum_d = checksum_d + headerByte(capHeader_q, b);
    end
    for (int s = 0; s < 4; s++) begin
      for (int b = 0; b < 7; b++) begin
        checksum_d = checksum_d + subByte(capSub_q[s], b);
      end
    end
  end

  // Capture, dispatch and FSM state with registered outputs and one-cycle pulses
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      capValid_q      <= 1'b0;
      capHeader_q     <= '0;
      capSub_q        <= '0;
      cts_q           <= '0;
      n_q             <= '0;
      acrValid_q      <= 1'b0;
      vic_q           <= '0;
      channelCount_q  <= '0;
      checksumError_q <= 1'b0;
      protocolError_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      acrValid_q      <= 1'b0;
      checksumError_q <= 1'b0;
      protocolError_q <= 1'b0;
      capValid_q      <= accept_d && !busy_d;
      if (accept_d) begin
        if (busy_d) begin
          protocolError_q <= 1'b1;
        end else begin
          capHeader_q <= header;
          capSub_q    <= sub;
        end
      end
      if (capValid_q) begin
        case (hb0)
          ACR: begin
            cts_q      <= {capSub_q[0][11:8], capSub_q[0][23:16], capSub_q[0][31:24]};
            n_q        <= {capSub_q[0][35:32], capSub_q[0][47:40], capSub_q[0][55:48]};
            acrValid_q <= 1'b1;
          end
          AVI: begin
            if (checksum_d == 8'h00) begin
              vic_q <= capSub_q[0][38:32];
            end else begin
              checksumError_q <= 1'b1;
            end
          end
          AUDIO_INFO: begin
            if (checksum_d == 8'h00) begin
              channelCount_q <= capSub_q[0][10:8];
            end else begin
              checksumError_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  hdmi_audio_sample_fifo #(
    .DEPTH(SAMPLE_FIFO_DEPTH)
  ) sampleFifo (
    .clk_i           (clk_pixel),
    .reset_n_i       (reset_n),
    .push_valid_i    (pushValid_d),
    .push_data_i     (pushEntry_d),
    .pop_ready_i     (audio_sample_ready),
    .pop_valid_o     (audio_sample_valid),
    .pop_data_o      (fifoHead),
    .overflow_count_o(sample_overflow_count)
  );

  assign audio_sample_word[0]      = fifoHead.left[AUDIO_BIT_WIDTH-1:0];
  assign audio_sample_word[1]      = fifoHead.right[AUDIO_BIT_WIDTH-1:0];
  assign audio_block_start         = fifoHead.blockStart;
  assign unusedHighBits            = ^{fifoHead.left >> AUDIO_BIT_WIDTH, fifoHead.right >> AUDIO_BIT_WIDTH};
  assign cts                       = cts_q;
  assign n                         = n_q;
  assign acr_valid                 = acrValid_q;
  assign video_id_code             = vic_q;
  assign channel_count             = channelCount_q;
  assign info_frame_checksum_error = checksumError_q;
  assign protocol_error            = protocolError_q;

endmodule

// File: tb/tb_hdmi_packet_receiver.sv
// Directed bench for hdmi_packet_receiver: ACR, InfoFrame, audio unpack,
// FIFO overflow, protocol error and mid-unpack reset. Expected audio samples
// are queued when a packet is driven and compared as the DUT pops them.
module tb_hdmi_packet_receiver;

  localparam int W     = 16;
  localparam int DEPTH = 8;

  logic                clk_pixel = 1'b0;
  logic                reset_n = 1'b0;
  logic                packet_valid = 1'b0;
  logic                ecc_error = 1'b0;
  logic [23:0]         header = '0;
  logic [3:0][55:0]    sub = '0;
  logic [1:0][W-1:0]   audio_sample_word;
  logic                audio_block_start;
  logic                audio_sample_valid;
  logic                audio_sample_ready = 1'b0;
  logic [19:0]         cts;
  logic [19:0]         n;
  logic                acr_valid;
  logic [6:0]          video_id_code;
  logic [2:0]          channel_count;
  logic                info_frame_checksum_error;
  logic [7:0]          sample_overflow_count;
  logic                protocol_error;

  typedef struct packed {
    logic [W-1:0] left;
    logic [W-1:0] right;
    logic         blockStart;
  } expSample_t;

  expSample_t sbQueue[$];
  expSample_t popped;
  int compareCount = 0;
  int failCount = 0;

  hdmi_packet_receiver #(
    .AUDIO_BIT_WIDTH  (W),
    .SAMPLE_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_pixel                (clk_pixel),
    .reset_n                  (reset_n),
    .packet_valid             (packet_valid),
    .ecc_error                (ecc_error),
    .header                   (header),
    .sub                      (sub),
    .audio_sample_word        (audio_sample_word),
    .audio_block_start        (audio_block_start),
    .audio_sample_valid       (audio_sample_valid),
    .audio_sample_ready       (audio_sample_ready),
    .cts                      (cts),
    .n                        (n),
    .acr_valid                (acr_valid),
    .video_id_code            (video_id_code),
    .channel_count            (channel_count),
    .info_frame_checksum_error(info_frame_checksum_error),
    .sample_overflow_count    (sample_overflow_count),
    .protocol_error           (protocol_error)
  );

  // Pixel clock
  always #5 clk_pixel = ~clk_pixel;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one packet for a single cycle; returns just after the capture edge
  task automatic applyStimulus(input logic [23:0] hdr, input logic [3:0][55:0] s, input logic ecc);
    @(negedge clk_pixel);
    header       = hdr;
    sub          = s;
    ecc_error    = ecc;
    packet_valid = 1'b1;
    @(negedge clk_pixel);
    packet_valid = 1'b0;
    ecc_error    = 1'b0;
  endtask

  task automatic pushExpected(input logic [23:0] l, input logic [23:0] r, input logic bs);
    expSample_t e;
    e.left       = l[W-1:0];
    e.right      = r[W-1:0];
    e.blockStart = bs;
    sbQueue.push_back(e);
  endtask

  function automatic logic [55:0] audioSub(input logic [23:0] l, input logic [23:0] r);
    return {8'h00, r, l};
  endfunction

  function automatic logic [23:0] audioHeader(input logic [3:0] present, input logic [3:0] b);
    return {b, 4'h0, 4'h0, present, 8'h02};
  endfunction

  // Checksum byte that makes the whole packet sum to zero (SB0 of sub[0] taken as 0)
  function automatic logic [7:0] infoChecksum(input logic [23:0] hdr, input logic [3:0][55:0] s);
    int sum;
    sum = hdr[7:0] + hdr[15:8] + hdr[23:16];
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 7; b++) begin
        if (!(k == 0 && b == 0)) sum += s[k][b*8 +: 8];
      end
    end
    return 8'((256 - (sum % 256)) % 256);
  endfunction

  // Scoreboard: compare every popped sample against the head of the queue
  always begin
    @(negedge clk_pixel);
    #1;
    if (reset_n && audio_sample_valid && audio_sample_ready) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_sample", 64'd1, 64'd0);
      end else begin
        popped = sbQueue.pop_front();
        checkOutput("sample_left", audio_sample_word[0], popped.left);
        checkOutput("sample_right", audio_sample_word[1], popped.right);
        checkOutput("sample_block_start", audio_block_start, popped.blockStart);
      end
    end
  end

  initial begin
    logic [3:0][55:0] s;
    logic [3:0][55:0] sB;
    logic [23:0] h;
    logic [23:0] l;
    logic [23:0] r;

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk_pixel);
    reset_n = 1'b1;
    @(negedge clk_pixel);
    checkOutput("reset_valid", audio_sample_valid, 0);
    checkOutput("reset_word", audio_sample_word, 0);
    checkOutput("reset_cts", cts, 0);
    checkOutput("reset_n", n, 0);
    checkOutput("reset_vic", video_id_code, 0);
    checkOutput("reset_overflow", sample_overflow_count, 0);
    checkOutput("reset_acr_valid", acr_valid, 0);

    // ACR: cts=74250, n=6144
    s = '0;
    s[0] = 56'h00_18_00_0A_22_01_00;
    applyStimulus(24'h000001, s, 1'b0);
    checkOutput("acr_valid_at_T", acr_valid, 0);
    @(negedge clk_pixel);
    checkOutput("acr_valid_T1", acr_valid, 1);
    checkOutput("acr_cts", cts, 20'd74250);
    checkOutput("acr_n", n, 20'd6144);
    @(negedge clk_pixel);
    checkOutput("acr_valid_T2", acr_valid, 0);

    // ACR with ecc_error (different payload) is ignored
    s[0] = 56'h00_10_00_D2_04_00_00;
    applyStimulus(24'h000001, s, 1'b1);
    @(negedge clk_pixel);
    checkOutput("ecc_acr_valid", acr_valid, 0);
    @(negedge clk_pixel);
    checkOutput("ecc_cts", cts, 20'd74250);
    checkOutput("ecc_n", n, 20'd6144);

    // Unknown type with ACR-shaped payload is discarded
    applyStimulus(24'h000003, s, 1'b0);
    @(negedge clk_pixel);
    checkOutput("unknown_acr_valid", acr_valid, 0);
    checkOutput("unknown_cts", cts, 20'd74250);

    // Audio: present=1011, B=0001; sub[2] must not appear, 24->16 truncation
    audio_sample_ready = 1'b1;
    s[0] = audioSub(24'h000123, 24'h000456);
    s[1] = audioSub(24'h7A1234, 24'h5B5678);
    s[2] = audioSub(24'h111111, 24'h222222);
    s[3] = audioSub(24'h00BEEF, 24'hC0FFEE);
    pushExpected(24'h000123, 24'h000456, 1'b1);
    pushExpected(24'h7A1234, 24'h5B5678, 1'b0);
    pushExpected(24'h00BEEF, 24'hC0FFEE, 1'b0);
    applyStimulus(audioHeader(4'b1011, 4'b0001), s, 1'b0);
    repeat (8) @(negedge clk_pixel);
    checkOutput("audio_drained", sbQueue.size(), 0);
    checkOutput("audio_valid_low", audio_sample_valid, 0);

    // AVI with VIC=16 and a correct checksum
    h = 24'h0D0282;
    s = '0;
    s[0][15:8]  = 8'h10;
    s[0][23:16] = 8'h08;
    s[0][39:32] = 8'd16;
    s[0][7:0]   = infoChecksum(h, s);
    applyStimulus(h, s, 1'b0);
    @(negedge clk_pixel);
    checkOutput("avi_vic", video_id_code, 7'd16);
    checkOutput("avi_cs_err", info_frame_checksum_error, 0);

    // AVI with VIC=5 and checksum off by one: rejected
    s[0][39:32] = 8'd5;
    s[0][7:0]   = infoChecksum(h, s) + 8'd1;
    applyStimulus(h, s, 1'b0);
    @(negedge clk_pixel);
    checkOutput("avi_bad_cs_err", info_frame_checksum_error, 1);
    checkOutput("avi_bad_vic", video_id_code, 7'd16);
    @(negedge clk_pixel);
    checkOutput("avi_bad_cs_err_pulse", info_frame_checksum_error, 0);

    // Audio InfoFrame with CC=3
    h = 24'h0A0184;
    s = '0;
    s[0][15:8] = 8'h03;
    s[0][7:0]  = infoChecksum(h, s);
    applyStimulus(h, s, 1'b0);
    @(negedge clk_pixel);
    checkOutput("ainfo_cc", channel_count, 3'd3);
    checkOutput("ainfo_cs_err", info_frame_checksum_error, 0);

    // Overflow: ready low, three 4-sample packets into an 8-deep FIFO
    audio_sample_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) begin
        l = {8'h00, 8'(p), 8'(i)};
        r = {8'hA0, 8'(p), 8'(i + 8)};
        s[i] = audioSub(l, r);
        if (p < 2) pushExpected(l, r, (i == 0) || (i == 2));
      end
      applyStimulus(audioHeader(4'b1111, 4'b0101), s, 1'b0);
      if (p == 0) begin
        checkOutput("latency_valid_T", audio_sample_valid, 0);
        @(negedge clk_pixel);
        checkOutput("latency_valid_T1", audio_sample_valid, 1);
      end
      repeat (5) @(negedge clk_pixel);
    end
    repeat (2) @(negedge clk_pixel);
    checkOutput("overflow_count", sample_overflow_count, 8'd4);
    checkOutput("overflow_valid_held", audio_sample_valid, 1);
    audio_sample_ready = 1'b1;
    repeat (12) @(negedge clk_pixel);
    checkOutput("overflow_drained", sbQueue.size(), 0);
    checkOutput("overflow_valid_low", audio_sample_valid, 0);

    // Second packet two cycles after a present=F audio packet
    for (int i = 0; i < 4; i++) begin
      l = {8'h55, 8'h00, 8'(i + 16)};
      r = {8'h66, 8'h00, 8'(i + 32)};
      s[i]  = audioSub(l, r);
      sB[i] = audioSub(24'hEEEE00 + 24'(i), 24'hDDDD00 + 24'(i));
      pushExpected(l, r, i == 3);
    end
    @(negedge clk_pixel);
    header = audioHeader(4'b1111, 4'b1000);
    sub = s;
    packet_valid = 1'b1;
    @(negedge clk_pixel);
    packet_valid = 1'b0;
    @(negedge clk_pixel);
    checkOutput("proto_err_before", protocol_error, 0);
    header = audioHeader(4'b1111, 4'b0000);
    sub = sB;
    packet_valid = 1'b1;
    @(negedge clk_pixel);
    packet_valid = 1'b0;
    checkOutput("proto_err_pulse", protocol_error, 1);
    @(negedge clk_pixel);
    checkOutput("proto_err_clear", protocol_error, 0);
    repeat (8) @(negedge clk_pixel);
    checkOutput("proto_drained", sbQueue.size(), 0);
    checkOutput("proto_valid_low", audio_sample_valid, 0);

    // Reset during UNPACK
    audio_sample_ready = 1'b0;
    applyStimulus(audioHeader(4'b1111, 4'b0001), s, 1'b0);
    @(negedge clk_pixel);
    checkOutput("mid_unpack_valid", audio_sample_valid, 1);
    reset_n = 1'b0;
    @(negedge clk_pixel);
    checkOutput("rst_valid", audio_sample_valid, 0);
    checkOutput("rst_word", audio_sample_word, 0);
    checkOutput("rst_block_start", audio_block_start, 0);
    checkOutput("rst_cts", cts, 0);
    checkOutput("rst_n", n, 0);
    checkOutput("rst_vic", video_id_code, 0);
    checkOutput("rst_cc", channel_count, 0);
    checkOutput("rst_overflow", sample_overflow_count, 0);
    reset_n = 1'b1;
    audio_sample_ready = 1'b1;
    s[0] = audioSub(24'h00ABCD, 24'h00DCBA);
    pushExpected(24'h00ABCD, 24'h00DCBA, 1'b1);
    applyStimulus(audioHeader(4'b0001, 4'b0001), s, 1'b0);
    repeat (6) @(negedge clk_pixel);
    checkOutput("post_rst_drained", sbQueue.size(), 0);
    checkOutput("post_rst_valid_low", audio_sample_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/hdmi_packet_receiver.md
Name: hdmi_packet_receiver

Overview:
- Sink-side counterpart of the data-island packet scheduler.
- Accepts one decoded, BCH-checked data-island packet at a time: header plus four subpackets, delivered by the TMDS/data-island deserializer.
- Dispatches the packet by type:
  - audio sample packets are unpacked into a sample FIFO;
  - ACR packets update the N/CTS registers;
  - AVI and Audio InfoFrames are checksum-validated and latched.
- Sits between the data-island decoder and the audio/video recovery logic.

Parameters:
AUDIO_BIT_WIDTH, 16, output sample width; 16..24
SAMPLE_FIFO_DEPTH, 8, sample FIFO entries; power of two, >= 4

Ports:
clk_pixel  input  1  pixel clock; all logic on rising edge
reset_n  input  1  synchronous reset, active low
packet_valid  input  1  one-cycle strobe: header/sub valid
ecc_error  input  1  qualifies packet_valid; packet had an uncorrectable BCH error
header  input  24  {HB2,HB1,HB0}
sub  input  4x56  subpackets; each {SB6..SB0}; sub[0] carries PB0..PB6
audio_sample_word  output  2x AUDIO_BIT_WIDTH  [0]=left, [1]=right
audio_block_start  output  1  IEC 60958 B flag of the current output sample
audio_sample_valid  output  1  FIFO not empty
audio_sample_ready  input  1  consumer pop
cts  output  20  last ACR CTS
n  output  20  last ACR N
acr_valid  output  1  one-cycle pulse on ACR update
video_id_code  output  7  last valid AVI VIC
channel_count  output  3  Audio InfoFrame CC field
info_frame_checksum_error  output  1  one-cycle pulse
sample_overflow_count  output  8  saturating count of dropped samples
protocol_error  output  1  one-cycle pulse

Behaviour:
Reset (reset_n=0 at an edge):
- All outputs and state go to 0: FIFO empty, FSM IDLE.
- Reset has priority over every other event, including a packet arriving mid-unpack.

Capture stage:
- packet_valid=1 with ecc_error=0 registers header/sub at edge T.
- packet_valid with ecc_error=1 is ignored; no output changes.

Dispatch on captured HB0 (decisions take effect at edge T+1):
- 0x00 (null) and unknown types: discarded.
- 0x01 ACR, taken from sub[0]:
  - cts={SB1[3:0],SB2,SB3}; n={SB4[3:0],SB5,SB6}.
  - acr_valid high for one cycle, cycle T+1.
- 0x82 AVI and 0x84 Audio InfoFrame:
  - Checksum is the mod-256 sum of HB0..HB2 and the 28 bytes SB0..SB6 of sub[0..3]; it must equal 0.
  - Pass, 0x82: video_id_code = PB4[6:0] (sub[0][38:32]).
  - Pass, 0x84: channel_count = PB1[2:0] (sub[0][10:8]).
  - Fail: registers unchanged; info_frame_checksum_error pulses for one cycle.
- 0x02 audio sample:
  - Decode present=HB1[3:0] and B=HB2[7:4].
  - Enter UNPACK with the index at the lowest set present bit.
  - present=0 returns straight to IDLE with nothing written.

Unpack FSM (states IDLE, UNPACK):
- Each cycle in UNPACK pushes subpacket i as one entry:
  - left = SB2..SB0, right = SB5..SB3, truncated to bits [AUDIO_BIT_WIDTH-1:0] of each 24-bit field;
  - flag = B[i].
- Advances to the next set present bit; returns to IDLE after the highest one.
- Takes at most 4 cycles.
- packet_valid in UNPACK (any type): packet dropped, protocol_error pulses, unpack continues.

Sample FIFO:
- Registered output; first-word fall-through.
- audio_sample_valid = not empty. A pop happens when valid && ready; ready with valid low is a no-op.
- Push when full:
  - if a pop occurs in the same cycle, the push succeeds;
  - otherwise the sample is dropped and sample_overflow_count increments, saturating at 255.
- Word order is preserved across packets.

Latency:
- Capture edge T. ACR/InfoFrame outputs change at edge T+1.
- First sample is written at edge T+1 and visible with audio_sample_valid in cycle T+1 after that edge.

Decomposition:
- Package hdmi_packet_pkg holds:
  - packet type constants: NULL=8'h00, ACR=8'h01, AUDIO_SAMPLE=8'h02, AVI=8'h82, AUDIO_INFO=8'h84;
  - the audio sample entry typedef (left, right, block_start);
  - byte-extract helper functions.
- Sub-module hdmi_audio_sample_fifo: synchronous FIFO, same clock/reset, carrying the overflow counter.
- Top module holds the capture register, checksum, dispatch and unpack FSM.

Test Plan:
1. ACR packet with cts=74250, n=6144 -> acr_valid pulses exactly once at T+1 with cts=20'd74250, n=20'd6144; the same packet with ecc_error=1 -> no pulse, values unchanged.
2. Audio packet, present=4'b1011, B=4'b0001, L0=24'h000123, R0=24'h000456, AUDIO_BIT_WIDTH=16, ready=1 -> three samples in order:
   - sample 0: words 16'h0123/16'h0456 with audio_block_start=1;
   - sample 1: audio_block_start=0;
   - sample 3: audio_block_start=0;
   - then valid falls.
3. AVI frame with VIC=16 and a correct checksum -> video_id_code=7'd16. Same frame with PB0+1 -> info_frame_checksum_error pulses, video_id_code stays 16.
4. ready=0, DEPTH=8, three 4-sample packets -> valid held, 8 entries stored, sample_overflow_count=4. Then drain with ready=1 -> the first 8 samples come out in order.
5. Second packet_valid two cycles after an audio packet with present=4'hF -> protocol_error pulse, all 4 original samples written, second packet lost.
6. reset_n=0 during UNPACK -> next cycle: FIFO empty, all outputs 0; a new packet after release decodes normally.
